vector_reduce_lanes: RTL

//  Sequential lane-reduction unit at the output end of the 6-lane vector ALU datapath.

---
 rtl/vector_reduce_lanes.sv | 119 +++++++++++
 1 files changed

// File: rtl/vector_reduce_lanes.sv
// Sequential lane reducer: captures a packed LANES x N vector and folds one lane
// per cycle (sum/umax/umin/xor) into an N-bit scalar with {Carry, Zero} flags.
module vector_reduce_lanes #(
  parameter int N     = 8,
  parameter int LANES = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES*N-1:0] VecInE,
  input  logic [1:0]         RedOpE,
  input  logic               InValid,
  output logic               InReady,
  output logic [N-1:0]       ScalarOut,
  output logic [1:0]         RedFlags,
  output logic               OutValid,
  input  logic               OutReady
);

  localparam int IDXW = $clog2(LANES);

  localparam logic [1:0] OP_SUM  = 2'b00;
  localparam logic [1:0] OP_UMAX = 2'b01;
  localparam logic [1:0] OP_UMIN = 2'b10;

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [LANES*N-1:0] vec_reg, vec_next;
  logic [1:0]         op_reg, op_next;
  logic [N-1:0]       acc_reg, acc_next;
  logic [IDXW-1:0]    idx_reg, idx_next;
  logic               carry_reg, carry_next;

  logic [N-1:0] lanes_w [LANES];
  logic [N-1:0] lane_w;
  logic [N:0]   sum_w;
  logic [N-1:0] fold_w;
  logic         fold_c;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes_w[gi] = vec_reg[gi*N +: N];
    end
  endgenerate

  assign lane_w = lanes_w[idx_reg];
  assign sum_w  = {1'b0, acc_reg} + {1'b0, lane_w};

  // Ties on umax/umin keep the accumulator, so only strict compares swap.
  always_comb begin
    fold_w = acc_reg ^ lane_w;
    fold_c = 1'b0;
    case (op_reg)
      OP_SUM: begin
        fold_w = sum_w[N-1:0];
        fold_c = sum_w[N];
      end
      OP_UMAX: fold_w = (lane_w > acc_reg) ? lane_w : acc_reg;
      OP_UMIN: fold_w = (lane_w < acc_reg) ? lane_w : acc_reg;
      default: fold_w = acc_reg ^ lane_w;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    op_next    = op_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    carry_next = carry_reg;
    case (state_reg)
      IDLE: begin
        if (InValid) begin
          vec_next   = VecInE;
          op_next    = RedOpE;
          acc_next   = VecInE[N-1:0];
          idx_next   = IDXW'(1);
          carry_next = 1'b0;
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        acc_next   = fold_w;
        carry_next = carry_reg | fold_c;
        idx_next   = idx_reg + IDXW'(1);
        if (idx_reg == IDXW'(LANES - 1)) state_next = DONE;
      end
      DONE: begin
        if (OutReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      vec_reg   <= '0;
      op_reg    <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      op_reg    <= op_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      carry_reg <= carry_next;
    end
  end

  assign InReady   = (state_reg == IDLE);
  assign OutValid  = (state_reg == DONE);
  assign ScalarOut = OutValid ? acc_reg : '0;
  assign RedFlags  = OutValid ? {carry_reg, (acc_reg == '0)} : 2'b00;

endmodule
